rvfi_check_sequencer: RTL and testbench

RVFI_CHECK_SEQUENCER -- requirements
Module: rvfi_check_sequencer

---
 rtl/rvfi_check_sequencer.sv | 147 ++++++++++++++
 tb/tb_rvfi_check_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_check_sequencer.sv
// rvfi_check_sequencer: reset/run/trigger/check sequencer for one RVFI check.
// Ports: clock, reset, rvfi_valid[NRET] in; dut_reset, trig, check, cycle_count, state, done, trig_seen out.
module rvfi_check_sequencer #(
  parameter int NRET         = 1,
  parameter int CHANNEL_IDX  = 0,
  parameter int RESET_CYCLES = 1,
  parameter int TRIG_CYCLE   = 10,
  parameter int TRIG_WINDOW  = 4,
  parameter int CHECK_DELAY  = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NRET-1:0] rvfi_valid,
  output logic            dut_reset,
  output logic            trig,
  output logic            check,
  output logic [15:0]     cycle_count,
  output logic [2:0]      state,
  output logic            done,
  output logic            trig_seen
);

  if (NRET < 1) begin : g_bad_nret
    $error("NRET must be >= 1");
  end
  if (CHANNEL_IDX < 0 || CHANNEL_IDX >= NRET) begin : g_bad_idx
    $error("CHANNEL_IDX out of range");
  end
  if (RESET_CYCLES < 1) begin : g_bad_rc
    $error("RESET_CYCLES must be >= 1");
  end
  if (TRIG_CYCLE < 0 || TRIG_CYCLE > 65534) begin : g_bad_tc
    $error("TRIG_CYCLE out of range");
  end
  if (TRIG_WINDOW < 1) begin : g_bad_tw
    $error("TRIG_WINDOW must be >= 1");
  end
  if (CHECK_DELAY < 1) begin : g_bad_cd
    $error("CHECK_DELAY must be >= 1");
  end

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    RUN      = 3'd1,
    ARMED    = 3'd2,
    WAIT     = 3'd3,
    CHECK    = 3'd4,
    DONE     = 3'd5,
    MISS     = 3'd6
  } state_t;

  state_t      state_q, state_n;
  logic [31:0] hold_q, hold_n;
  logic [31:0] win_q, win_n;
  logic [31:0] wait_q, wait_n;
  logic [15:0] cc_q, cc_n;
  logic        seen_q, seen_n;
  logic        trig_w;

  assign trig_w = (state_q == ARMED) && rvfi_valid[CHANNEL_IDX];

  always_comb begin
    state_n = state_q;
    hold_n  = hold_q;
    win_n   = win_q;
    wait_n  = wait_q;
    seen_n  = seen_q;
    // Count stays at 0 through RST_HOLD so the first RUN cycle reads 0.
    if (state_q == RST_HOLD) begin
      cc_n = 16'd0;
    end else if (cc_q == 16'hFFFF) begin
      cc_n = cc_q;
    end else begin
      cc_n = cc_q + 16'd1;
    end
    case (state_q)
      RST_HOLD: begin
        if (hold_q == 32'(RESET_CYCLES - 1)) begin
          hold_n  = 32'd0;
          state_n = (TRIG_CYCLE == 0) ? ARMED : RUN;
        end else begin
          hold_n = hold_q + 32'd1;
        end
      end
      RUN: begin
        if (cc_q == 16'(TRIG_CYCLE - 1)) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        // A trig in the final window cycle still wins over MISS.
        if (trig_w) begin
          seen_n  = 1'b1;
          win_n   = 32'd0;
          state_n = (CHECK_DELAY == 1) ? CHECK : WAIT;
        end else if (win_q == 32'(TRIG_WINDOW - 1)) begin
          win_n   = 32'd0;
          state_n = MISS;
        end else begin
          win_n = win_q + 32'd1;
        end
      end
      WAIT: begin
        if (wait_q == 32'(CHECK_DELAY - 2)) begin
          wait_n  = 32'd0;
          state_n = CHECK;
        end else begin
          wait_n = wait_q + 32'd1;
        end
      end
      CHECK:   state_n = DONE;
      DONE:    state_n = DONE;
      MISS:    state_n = MISS;
      default: state_n = RST_HOLD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RST_HOLD;
      hold_q    <= 32'd0;
      win_q     <= 32'd0;
      wait_q    <= 32'd0;
      cc_q      <= 16'd0;
      seen_q    <= 1'b0;
      dut_reset <= 1'b1;
      check     <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_n;
      hold_q    <= hold_n;
      win_q     <= win_n;
      wait_q    <= wait_n;
      cc_q      <= cc_n;
      seen_q    <= seen_n;
      dut_reset <= (state_n == RST_HOLD);
      check     <= (state_n == CHECK);
      done      <= (state_n == DONE) || (state_n == MISS);
    end
  end

  assign trig        = trig_w;
  assign cycle_count = cc_q;
  assign state       = state_q;
  assign trig_seen   = seen_q;

endmodule

// File: tb/tb_rvfi_check_sequencer.sv
// tb_rvfi_check_sequencer: checks three sequencer configurations
// against a cycle-indexed model of the trigger/check timeline.
module tb_rvfi_check_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_a = 1'b1;
  logic       reset_b = 1'b1;
  logic       reset_c = 1'b1;
  logic [0:0] va = 1'b0;
  logic [1:0] vb = 2'b00;
  logic [0:0] vc = 1'b0;

  logic        dr_a, tg_a, ck_a, dn_a, ts_a;
  logic [15:0] cc_a;
  logic [2:0]  st_a;
  logic        dr_b, tg_b, ck_b, dn_b, ts_b;
  logic [15:0] cc_b;
  logic [2:0]  st_b;
  logic        dr_c, tg_c, ck_c, dn_c, ts_c;
  logic [15:0] cc_c;
  logic [2:0]  st_c;

  rvfi_check_sequencer u_a (
    .clock(clock), .reset(reset_a), .rvfi_valid(va),
    .dut_reset(dr_a), .trig(tg_a), .check(ck_a),
    .cycle_count(cc_a), .state(st_a), .done(dn_a),
    .trig_seen(ts_a)
  );

  rvfi_check_sequencer #(
    .NRET(2), .CHANNEL_IDX(1)
  ) u_b (
    .clock(clock), .reset(reset_b), .rvfi_valid(vb),
    .dut_reset(dr_b), .trig(tg_b), .check(ck_b),
    .cycle_count(cc_b), .state(st_b), .done(dn_b),
    .trig_seen(ts_b)
  );

  rvfi_check_sequencer #(
    .TRIG_CYCLE(0), .RESET_CYCLES(3), .CHECK_DELAY(1)
  ) u_c (
    .clock(clock), .reset(reset_c), .rvfi_valid(vc),
    .dut_reset(dr_c), .trig(tg_c), .check(ck_c),
    .cycle_count(cc_c), .state(st_c), .done(dn_c),
    .trig_seen(ts_c)
  );

  int ntests = 0;
  int nfail  = 0;

  int rc_t [3] = '{1, 1, 3};
  int tc_t [3] = '{10, 10, 0};
  int tw_t [3] = '{4, 4, 4};
  int cd_t [3] = '{2, 2, 1};
  int ch_t [3] = '{0, 1, 0};

  logic [1:0] vp [0:63];

  task automatic chk(input string tag, input int obs, input int exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int cfg, input logic rst,
                       input logic [1:0] v);
    case (cfg)
      0: begin reset_a = rst; va = v[0]; end
      1: begin reset_b = rst; vb = v; end
      default: begin reset_c = rst; vc = v[0]; end
    endcase
  endtask

  task automatic sample(input int cfg,
                        output int dr, output int tg,
                        output int ck, output int dn,
                        output int ts, output int cc,
                        output int st);
    case (cfg)
      0: begin
        dr = int'(dr_a); tg = int'(tg_a); ck = int'(ck_a);
        dn = int'(dn_a); ts = int'(ts_a); cc = int'(cc_a);
        st = int'(st_a);
      end
      1: begin
        dr = int'(dr_b); tg = int'(tg_b); ck = int'(ck_b);
        dn = int'(dn_b); ts = int'(ts_b); cc = int'(cc_b);
        st = int'(st_b);
      end
      default: begin
        dr = int'(dr_c); tg = int'(tg_c); ck = int'(ck_c);
        dn = int'(dn_c); ts = int'(ts_c); cc = int'(cc_c);
        st = int'(st_c);
      end
    endcase
  endtask

  // k counts cycles from the first cycle with reset low.
  task automatic run(input string name, input int cfg,
                     input int abort_k);
    int rc, tc, tw, cd, ch, nk, tk;
    int e_st, e_cc;
    int dr, tg, ck, dn, ts, cc, st;
    bit found;
    string t;
    rc = rc_t[cfg]; tc = tc_t[cfg]; tw = tw_t[cfg];
    cd = cd_t[cfg]; ch = ch_t[cfg];
    nk = rc + tc + tw + cd + 4;
    found = 1'b0;
    tk = 0;
    for (int k = rc + tc; k < rc + tc + tw; k++) begin
      if (!found && vp[k][ch]) begin
        found = 1'b1;
        tk = k;
      end
    end
    @(negedge clock);
    drive(cfg, 1'b1, 2'b00);
    @(negedge clock);
    for (int k = 0; k < nk; k++) begin
      drive(cfg, 1'b0, vp[k]);
      #1;
      e_cc = (k < rc) ? 0 : k - rc;
      if (k < rc) e_st = 0;
      else if (e_cc < tc) e_st = 1;
      else if (found) begin
        if (k <= tk) e_st = 2;
        else if (k < tk + cd) e_st = 3;
        else if (k == tk + cd) e_st = 4;
        else e_st = 5;
      end else begin
        e_st = (e_cc < tc + tw) ? 2 : 6;
      end
      sample(cfg, dr, tg, ck, dn, ts, cc, st);
      t = $sformatf("%s k=%0d", name, k);
      chk({t, " state"}, st, e_st);
      chk({t, " cycle_count"}, cc, e_cc);
      chk({t, " dut_reset"}, dr, int'(k < rc));
      chk({t, " trig"}, tg, int'(found && k == tk));
      chk({t, " check"}, ck, int'(e_st == 4));
      chk({t, " done"}, dn, int'(e_st >= 5));
      chk({t, " trig_seen"}, ts, int'(found && k > tk));
      if (k == abort_k) begin
        drive(cfg, 1'b1, vp[k]);
        @(negedge clock);
        drive(cfg, 1'b0, 2'b11);
        #1;
        sample(cfg, dr, tg, ck, dn, ts, cc, st);
        t = {name, " post-abort"};
        chk({t, " state"}, st, 0);
        chk({t, " dut_reset"}, dr, 1);
        chk({t, " check"}, ck, 0);
        chk({t, " trig"}, tg, 0);
        chk({t, " trig_seen"}, ts, 0);
        chk({t, " done"}, dn, 0);
        chk({t, " cycle_count"}, cc, 0);
        return;
      end
      @(negedge clock);
    end
  endtask

  task automatic fill(input logic [1:0] v);
    for (int k = 0; k < 64; k++) vp[k] = v;
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);

    fill(2'b01);
    run("defaults_all_valid", 0, -1);

    fill(2'b00);
    run("window_miss", 0, -1);

    fill(2'b00);
    vp[1 + 10] = 2'b01;
    vp[1 + 11] = 2'b01;
    vp[1 + 12] = 2'b10;
    run("channel_select", 1, -1);

    fill(2'b01);
    run("trig_at_zero", 2, -1);

    fill(2'b01);
    run("abort_in_wait", 0, 12);
    run("after_abort", 0, -1);

    fill(2'b00);
    vp[1 + 13] = 2'b01;
    run("last_window_cycle", 0, -1);

    fill(2'b10);
    run("other_channel_only", 1, -1);

    for (int r = 0; r < 8; r++) begin
      for (int cfg = 0; cfg < 3; cfg++) begin
        for (int k = 0; k < 64; k++) begin
          vp[k][0] = ($urandom_range(0, 5) == 0);
          vp[k][1] = ($urandom_range(0, 5) == 0);
        end
        run($sformatf("rand%0d_cfg%0d", r, cfg), cfg, -1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
